march_bist_ctrl: RTL and testbench

Parametrised March C- built-in self-test controller for a single-port synchronous SRAM of 2^ADDR_W words × DATA_W bits. It supersedes the fixed 256×4 blanket write/read sweep with the following:
- start/busy/done handshake
- up/down address sequencing
- selectable data background
- first-fail capture and a saturating fail counter

It sits between the SRAM instance and the chip-level test pins, and drives the SRAM address, write-enable and data-in directly.

---
 rtl/march_bist_pkg.sv | 34 +++
 rtl/bist_addr_gen.sv | 38 +++
 rtl/march_bist_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_march_bist_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/march_bist_pkg.sv
// Shared types for the March C- BIST controller: FSM states, element index
// and the per-element operation table.
package march_bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef logic [2:0] elem_t;

  localparam elem_t LAST_ELEM = 3'd5;

  typedef struct packed {
    logic down;       // 1: address N-1 -> 0
    logic has_read;
    logic has_write;
    logic rd_pol;     // 0/1 relative to the data background
    logic wr_pol;
  } elem_cfg_t;

  // E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 down(r0,w1) E4 down(r1,w0) E5 up(r0)
  function automatic elem_cfg_t elem_cfg(elem_t e);
    elem_cfg_t c;
    case (e)
      3'd0:    c = '{down: 1'b0, has_read: 1'b0, has_write: 1'b1, rd_pol: 1'b0, wr_pol: 1'b0};
      3'd1:    c = '{down: 1'b0, has_read: 1'b1, has_write: 1'b1, rd_pol: 1'b0, wr_pol: 1'b1};
      3'd2:    c = '{down: 1'b0, has_read: 1'b1, has_write: 1'b1, rd_pol: 1'b1, wr_pol: 1'b0};
      3'd3:    c = '{down: 1'b1, has_read: 1'b1, has_write: 1'b1, rd_pol: 1'b0, wr_pol: 1'b1};
      3'd4:    c = '{down: 1'b1, has_read: 1'b1, has_write: 1'b1, rd_pol: 1'b1, wr_pol: 1'b0};
      3'd5:    c = '{down: 1'b0, has_read: 1'b1, has_write: 1'b0, rd_pol: 1'b0, wr_pol: 1'b0};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down SRAM address counter: loads 0 or N-1 at the start of an element and
// flags the terminal address for the current direction.
module bist_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              load_hi_i,
  input  logic              step_i,
  input  logic              down_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              term_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_hi_i ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
    end else if (step_i) begin
      addr_d = down_i ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign term_o = down_i ? (addr_q == {ADDR_W{1'b0}}) : (addr_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- BIST controller for a single-port synchronous SRAM: sequences the
// six March elements, compares reads two cycles later and records failures.
module march_bist_ctrl
  import march_bist_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 4,
  parameter int BACKGROUND = 0,
  parameter int CNT_W      = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic              GoNoGo,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic              Mem_WE,
  output logic [DATA_W-1:0] Mem_Data_in,
  input  logic [DATA_W-1:0] Mem_Data_out,
  output logic [ADDR_W-1:0] Fail_Address,
  output logic [CNT_W-1:0]  Fail_Count
);

  localparam logic [DATA_W-1:0] BG0 = (BACKGROUND != 0) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] BG1 = ~BG0;

  state_t            state_q, state_d;
  elem_t             elem_q, elem_d;
  logic              phase_q, phase_d;
  logic              down_q, down_d;
  logic              dual_q, dual_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              gng_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] faddr_q;

  elem_cfg_t         nx_cfg;
  logic              run_d, pol_d, last_op, clear_fail;
  logic              ag_load, ag_load_hi, ag_step;
  logic [ADDR_W-1:0] addr;
  logic              term;

  logic              vld_p0;
  logic [DATA_W-1:0] exp_p0;
  logic [ADDR_W-1:0] addr_p0;

  bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .load_i    (ag_load),
    .load_hi_i (ag_load_hi),
    .step_i    (ag_step),
    .down_i    (down_q),
    .addr_o    (addr),
    .term_o    (term)
  );

  // Registers describe the operation currently on the SRAM pins; the
  // combinational block selects the operation for the next cycle.
  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    phase_d    = phase_q;
    busy_d     = busy_q;
    done_d     = done_q;
    ag_load    = 1'b0;
    ag_step    = 1'b0;
    clear_fail = 1'b0;
    last_op    = ~dual_q | phase_q;

    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d    = RUN;
          elem_d     = '0;
          phase_d    = 1'b0;
          ag_load    = 1'b1;
          clear_fail = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end
      RUN: begin
        if (last_op) begin
          phase_d = 1'b0;
          if (term) begin
            if (elem_q == LAST_ELEM) begin
              state_d = DRAIN;
            end else begin
              elem_d  = elem_q + 3'd1;
              ag_load = 1'b1;
            end
          end else begin
            ag_step = 1'b1;
          end
        end else begin
          phase_d = 1'b1;
        end
      end
      DRAIN: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    nx_cfg     = elem_cfg(elem_d);
    ag_load_hi = ag_load & nx_cfg.down;
    down_d     = nx_cfg.down;
    dual_d     = nx_cfg.has_read & nx_cfg.has_write;
    run_d      = (state_d == RUN);
    rd_d       = run_d & nx_cfg.has_read & ~phase_d;
    we_d       = run_d & nx_cfg.has_write & ~rd_d;
    pol_d      = rd_d ? nx_cfg.rd_pol : nx_cfg.wr_pol;
    din_d      = run_d ? (pol_d ? BG1 : BG0) : din_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      elem_q  <= '0;
      phase_q <= 1'b0;
      down_q  <= 1'b0;
      dual_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      phase_q <= phase_d;
      down_q  <= down_d;
      dual_q  <= dual_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      din_q   <= din_d;
    end
  end

  // p0: read captured by the SRAM; its data is compared at the following edge
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= rd_q;
    end
  end

  always_ff @(posedge Clock) begin
    exp_p0  <= din_q;
    addr_p0 <= addr;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      gng_q   <= 1'b1;
      cnt_q   <= '0;
      faddr_q <= '0;
    end else if (clear_fail) begin
      gng_q   <= 1'b1;
      cnt_q   <= '0;
      faddr_q <= '0;
    end else if (vld_p0 && (Mem_Data_out != exp_p0)) begin
      gng_q <= 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (cnt_q == {CNT_W{1'b0}}) begin
        faddr_q <= addr_p0;
      end
    end
  end

  assign Busy         = busy_q;
  assign Done         = done_q;
  assign GoNoGo       = gng_q;
  assign Mem_Address  = addr;
  assign Mem_WE       = we_q;
  assign Mem_Data_in  = din_q;
  assign Fail_Address = faddr_q;
  assign Fail_Count   = cnt_q;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Bench for march_bist_ctrl: three configurations driving behavioural SRAMs
// with injectable faults, checked against an operation-list reference model.
module tb_march_bist_ctrl;

  typedef struct packed {
    logic [1:0] kind;  // 0 none, 1 stuck bit, 2 coupling, 3 all cells read 0
    logic [7:0] a;
    logic [7:0] v;
    logic [1:0] b;
    logic       sv;
  } fault_t;

  typedef struct {
    int a;
    bit we;
    bit pol;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic st[3];
  logic rs[3];
  fault_t flt[3];
  op_t ops[$];
  int n_chk = 0;
  int n_err = 0;

  logic busy0, done0, gng0, we0;
  logic [7:0] a0, fa0, fc0;
  logic [3:0] din0, dout0;
  logic busy1, done1, gng1, we1;
  logic [1:0] a1, fa1;
  logic [7:0] fc1;
  logic [0:0] din1, dout1;
  logic busy2, done2, gng2, we2;
  logic [7:0] a2, fa2;
  logic [3:0] fc2, din2, dout2;

  logic busy_s[3], done_s[3], gng_s[3], we_s[3];
  logic [7:0] a_s[3], fa_s[3], fc_s[3];

  assign busy_s[0] = busy0; assign busy_s[1] = busy1; assign busy_s[2] = busy2;
  assign done_s[0] = done0; assign done_s[1] = done1; assign done_s[2] = done2;
  assign gng_s[0]  = gng0;  assign gng_s[1]  = gng1;  assign gng_s[2]  = gng2;
  assign we_s[0]   = we0;   assign we_s[1]   = we1;   assign we_s[2]   = we2;
  assign a_s[0]    = a0;    assign a_s[1]    = {6'd0, a1}; assign a_s[2] = a2;
  assign fa_s[0]   = fa0;   assign fa_s[1]   = {6'd0, fa1}; assign fa_s[2] = fa2;
  assign fc_s[0]   = fc0;   assign fc_s[1]   = fc1;   assign fc_s[2]  = {4'd0, fc2};

  march_bist_ctrl #(.ADDR_W(8), .DATA_W(4), .BACKGROUND(0), .CNT_W(8)) dut0 (
    .Clock(clk), .Reset(rs[0]), .Start(st[0]), .Busy(busy0), .Done(done0), .GoNoGo(gng0),
    .Mem_Address(a0), .Mem_WE(we0), .Mem_Data_in(din0), .Mem_Data_out(dout0),
    .Fail_Address(fa0), .Fail_Count(fc0));

  march_bist_ctrl #(.ADDR_W(2), .DATA_W(1), .BACKGROUND(1), .CNT_W(8)) dut1 (
    .Clock(clk), .Reset(rs[1]), .Start(st[1]), .Busy(busy1), .Done(done1), .GoNoGo(gng1),
    .Mem_Address(a1), .Mem_WE(we1), .Mem_Data_in(din1), .Mem_Data_out(dout1),
    .Fail_Address(fa1), .Fail_Count(fc1));

  march_bist_ctrl #(.ADDR_W(8), .DATA_W(4), .BACKGROUND(1), .CNT_W(4)) dut2 (
    .Clock(clk), .Reset(rs[2]), .Start(st[2]), .Busy(busy2), .Done(done2), .GoNoGo(gng2),
    .Mem_Address(a2), .Mem_WE(we2), .Mem_Data_in(din2), .Mem_Data_out(dout2),
    .Fail_Address(fa2), .Fail_Count(fc2));

  function automatic fault_t mkf(int kind, int a, int v, int b, int sv);
    fault_t f;
    f.kind = 2'(kind); f.a = 8'(a); f.v = 8'(v); f.b = 2'(b); f.sv = 1'(sv);
    return f;
  endfunction

  function automatic logic [3:0] faulty_rd(fault_t f, logic [7:0] a, logic [3:0] d);
    logic [3:0] r;
    r = d;
    if (f.kind == 2'd1 && a == f.a) r[f.b] = f.sv;
    if (f.kind == 2'd3) r = 4'h0;
    return r;
  endfunction

  // Behavioural SRAMs: one-cycle synchronous read, faults applied on access
  logic [3:0] mem0 [256];
  logic [3:0] mem2 [256];
  logic [0:0] mem1 [4];

  always @(posedge clk) begin
    if (we0) begin
      mem0[a0] <= din0;
      if (flt[0].kind == 2'd2 && a0 == flt[0].a) mem0[flt[0].v][flt[0].b] <= ~mem0[flt[0].v][flt[0].b];
    end
    dout0 <= faulty_rd(flt[0], a0, mem0[a0]);
  end

  always @(posedge clk) begin
    if (we2) begin
      mem2[a2] <= din2;
      if (flt[2].kind == 2'd2 && a2 == flt[2].a) mem2[flt[2].v][flt[2].b] <= ~mem2[flt[2].v][flt[2].b];
    end
    dout2 <= faulty_rd(flt[2], a2, mem2[a2]);
  end

  always @(posedge clk) begin
    if (we1) mem1[a1] <= din1;
    dout1 <= mem1[a1];
  end

  // March C- as a flat list of operations for an n-word memory
  function automatic void build_ops(int n);
    int up [6]  = '{1, 1, 1, 0, 0, 1};
    int rdp [6] = '{-1, 0, 1, 0, 1, 0};
    int wrp [6] = '{0, 1, 0, 1, 0, -1};
    op_t o;
    ops.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < n; i++) begin
        o.a = (up[e] != 0) ? i : (n - 1 - i);
        if (rdp[e] >= 0) begin o.we = 1'b0; o.pol = 1'(rdp[e]); ops.push_back(o); end
        if (wrp[e] >= 0) begin o.we = 1'b1; o.pol = 1'(wrp[e]); ops.push_back(o); end
      end
    end
  endfunction

  function automatic void ref_sim(input fault_t f, input int bg, input int cmax,
                                  output int cnt, output int faddr, output bit gng);
    logic [3:0] m [256];
    logic [3:0] bg0, val, obs;
    int nf;
    bg0 = (bg != 0) ? 4'hF : 4'h0;
    for (int i = 0; i < 256; i++) m[i] = 4'h0;
    build_ops(256);
    nf = 0;
    faddr = 0;
    foreach (ops[j]) begin
      val = ops[j].pol ? ~bg0 : bg0;
      if (ops[j].we) begin
        m[ops[j].a] = val;
        if (f.kind == 2'd2 && ops[j].a == int'(f.a)) m[f.v][f.b] = ~m[f.v][f.b];
      end else begin
        obs = faulty_rd(f, 8'(ops[j].a), m[ops[j].a]);
        if (obs !== val) begin
          if (nf == 0) faddr = ops[j].a;
          nf++;
        end
      end
    end
    cnt = (nf > cmax) ? cmax : nf;
    gng = (nf == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_and_wait(input int sel, input int n, input bit hold);
    int lat;
    @(negedge clk) st[sel] = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("d%0d_busy_at_start", sel), busy_s[sel], 1);
    chk($sformatf("d%0d_done_at_start", sel), done_s[sel], 0);
    if (!hold) st[sel] = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10 * n + 50; c++) begin
      @(posedge clk); #1;
      if (done_s[sel] === 1'b1) begin lat = c; break; end
    end
    chk($sformatf("d%0d_done_latency", sel), lat, 10 * n + 1);
    chk($sformatf("d%0d_busy_at_done", sel), busy_s[sel], 0);
  endtask

  task automatic check_result(input int sel, input int bg, input int cmax);
    int ec, ea;
    bit eg;
    ref_sim(flt[sel], bg, cmax, ec, ea, eg);
    chk($sformatf("d%0d_gonogo", sel), gng_s[sel], eg);
    chk($sformatf("d%0d_fail_count", sel), fc_s[sel], ec);
    chk($sformatf("d%0d_fail_addr", sel), fa_s[sel], ea);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin st[i] = 1'b0; rs[i] = 1'b1; flt[i] = mkf(0, 0, 0, 0, 0); end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d_rst_busy", i), busy_s[i], 0);
      chk($sformatf("d%0d_rst_done", i), done_s[i], 0);
      chk($sformatf("d%0d_rst_gonogo", i), gng_s[i], 1);
      chk($sformatf("d%0d_rst_we", i), we_s[i], 0);
      chk($sformatf("d%0d_rst_addr", i), a_s[i], 0);
      chk($sformatf("d%0d_rst_fcnt", i), fc_s[i], 0);
      chk($sformatf("d%0d_rst_faddr", i), fa_s[i], 0);
    end
    chk("d0_rst_din", din0, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rs[i] = 1'b0;

    // Fault-free default configuration
    start_and_wait(0, 256, 0);
    check_result(0, 0, 255);

    // Bit 2 of 0x37 stuck-at-0
    flt[0] = mkf(1, 8'h37, 0, 2, 0);
    start_and_wait(0, 256, 0);
    check_result(0, 0, 255);

    // Operation trace on the 4-word, 1-bit instance (background ones)
    build_ops(4);
    @(negedge clk) st[1] = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 40; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      if (j == 0) st[1] = 1'b0;
      chk($sformatf("trace_addr_%0d", j), a_s[1], ops[j].a);
      chk($sformatf("trace_we_%0d", j), we_s[1], ops[j].we);
      chk($sformatf("trace_din_%0d", j), din1, ops[j].pol ? 0 : 1);
    end
    @(posedge clk); #1;
    chk("trace_we_after_last", we_s[1], 0);
    chk("trace_done_early", done_s[1], 0);
    @(posedge clk); #1;
    chk("trace_done", done_s[1], 1);
    chk("trace_busy", busy_s[1], 0);
    chk("trace_gonogo", gng_s[1], 1);
    chk("trace_fcnt", fc_s[1], 0);

    // Coupling fault and all-cells-stuck on the background-ones, 4-bit counter instance
    flt[2] = mkf(2, 8'h10, 8'h11, 0, 0);
    start_and_wait(2, 256, 0);
    check_result(2, 1, 15);
    flt[2] = mkf(3, 0, 0, 0, 0);
    start_and_wait(2, 256, 0);
    check_result(2, 1, 15);

    // Start held through a run, then reset part-way through the restarted run
    flt[0] = mkf(1, 8'h05, 0, 0, 1);
    start_and_wait(0, 256, 1);
    check_result(0, 0, 255);
    @(posedge clk); #1;
    chk("d0_restart_busy", busy0, 1);
    chk("d0_restart_done", done0, 0);
    st[0] = 1'b0;
    repeat (699) @(posedge clk);
    @(negedge clk);
    chk("d0_gonogo_before_reset", gng0, 0);
    rs[0] = 1'b1;
    @(posedge clk); #1;
    chk("d0_abort_busy", busy0, 0);
    chk("d0_abort_done", done0, 0);
    chk("d0_abort_we", we0, 0);
    chk("d0_abort_gonogo", gng0, 1);
    chk("d0_abort_fcnt", fc0, 0);
    chk("d0_abort_faddr", fa0, 0);
    @(posedge clk); #1;
    chk("d0_abort_we_hold", we0, 0);
    @(negedge clk) rs[0] = 1'b0;
    start_and_wait(0, 256, 0);
    check_result(0, 0, 255);

    // Random single faults
    for (int r = 0; r < 3; r++) begin
      int k, a;
      k = $urandom_range(0, 2);
      a = $urandom_range(0, 255);
      flt[0] = mkf(k, a, (a + $urandom_range(1, 255)) % 256, $urandom_range(0, 3), $urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      start_and_wait(0, 256, 0);
      check_result(0, 0, 255);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
